// File: rtl/io_load_sequencer.sv
// -----------------------------------------------------------------------------
// io_load_sequencer
//
// Boot-time loader for the UART word stream. After reset it consumes:
//   instruction count NI, NI instruction words   -> instr memory
//   data count ND,        ND data words          -> cache (req/ack handshake)
// then sends one status byte on the TX path. On success the core stall is
// released and every later word is forwarded to the core input buffer; on a
// header error a NAK byte is sent and the block parks until reset.
//
// Optional feature (macro LOAD_CHECKSUM_EN): one extra word after the data
// body carries the 32-bit wrapping sum of all body words. A mismatch is
// treated like a header error.
//
// Ports:
//   clk, rstn                    clock, asynchronous active-low reset
//   rdata_buf, rdata_buf_ready   received word and its one-cycle strobe
//   instr_we/addr/wd             instr memory write (combinational from strobe)
//   cache_init_done              cache can accept writes
//   data_req/addr/wd, data_ack   cache write request held until ack pulse
//   tx_data, tx_valid, tx_busy   status byte to the transmitter
//   input_wd, input_we           forwarded word to the core input buffer
//   io_stall                     core held while 1
//   overrun                      sticky: a word was dropped
//   load_err                     sticky: header (or checksum) error
// -----------------------------------------------------------------------------
module io_load_sequencer #(
  parameter logic [31:0] INSTR_BASE = 32'h0,
  parameter logic [31:0] DATA_BASE  = 32'h40000,
  parameter logic [31:0] MAX_WORDS  = 32'h10000,
  parameter logic [7:0]  ACK_BYTE   = 8'hAA,
  parameter logic [7:0]  NAK_BYTE   = 8'h55
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] rdata_buf,
  input  logic        rdata_buf_ready,
  output logic        instr_we,
  output logic [31:0] instr_addr,
  output logic [31:0] instr_wd,
  input  logic        cache_init_done,
  output logic        data_req,
  output logic [31:0] data_addr,
  output logic [31:0] data_wd,
  input  logic        data_ack,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_busy,
  output logic [31:0] input_wd,
  output logic        input_we,
  output logic        io_stall,
  output logic        overrun,
  output logic        load_err
);

  typedef enum logic [3:0] {
    S_IHDR,
    S_IBODY,
    S_DHDR,
    S_DBODY,
`ifdef LOAD_CHECKSUM_EN
    S_CSUM,
`endif
    S_CWAIT,
    S_ACK,
    S_NAK,
    S_RUN,
    S_ERR
  } state_t;

  state_t      state_q;
  logic [31:0] instr_addr_q;
  logic [31:0] ni_q;
  logic [31:0] nd_q;
  logic [31:0] rcv_q;       // body words counted in the current phase
  logic [31:0] resolved_q;  // data words acked or dropped
  logic        skid_vld_q;
  logic [31:0] skid_data_q;
`ifdef LOAD_CHECKSUM_EN
  logic [31:0] csum_q;
`endif

  // Data-body steering decisions for the current cycle
  logic        port_free;
  logic        ack_fire;
  logic        take;
  logic        extra;
  logic        drain;
  logic        direct;
  logic        to_skid;
  logic        drop;
  logic [31:0] resolved_nxt;

  // One idle cycle after each ack: the port is only free once data_req is low.
  assign port_free = cache_init_done && !data_req;

  // Pass-through paths are combinational from the strobe
  assign instr_we   = (state_q == S_IBODY) && rdata_buf_ready;
  assign instr_addr = instr_addr_q;
  assign instr_wd   = rdata_buf;
  assign input_we   = (state_q == S_RUN) && rdata_buf_ready;
  assign input_wd   = rdata_buf;

  always_comb begin
    ack_fire     = 1'b0;
    take         = 1'b0;
    extra        = 1'b0;
    drain        = 1'b0;
    direct       = 1'b0;
    to_skid      = 1'b0;
    drop         = 1'b0;
    resolved_nxt = resolved_q;
    if (state_q == S_DBODY) begin
      ack_fire = data_req && data_ack;
      // Words beyond ND are not part of the body; they are dropped uncounted.
      take     = rdata_buf_ready && (rcv_q != nd_q);
      extra    = rdata_buf_ready && (rcv_q == nd_q);
      drain    = port_free && skid_vld_q;
      // A word may bypass the skid only when nothing older is waiting.
      direct   = take && port_free && !skid_vld_q;
      // The skid accepts a word if empty or if it is emptying this cycle;
      // it is never overwritten while still holding an undrained word.
      to_skid  = take && !direct && (!skid_vld_q || drain);
      drop     = take && !direct && !to_skid;
      resolved_nxt = resolved_q + {31'd0, ack_fire} + {31'd0, drop};
    end
  end

  // --- control / FSM stage ---
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IHDR;
      instr_addr_q <= INSTR_BASE;
      data_addr    <= DATA_BASE;
      ni_q         <= '0;
      nd_q         <= '0;
      rcv_q        <= '0;
      resolved_q   <= '0;
      skid_vld_q   <= 1'b0;
      data_req     <= 1'b0;
      tx_valid     <= 1'b0;
      tx_data      <= 8'h00;
      io_stall     <= 1'b1;
      overrun      <= 1'b0;
      load_err     <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      tx_valid <= 1'b0;
      case (state_q)
        S_IHDR: begin
          if (rdata_buf_ready) begin
            ni_q  <= rdata_buf;
            rcv_q <= '0;
            if (rdata_buf > MAX_WORDS) begin
              load_err <= 1'b1;
              state_q  <= S_NAK;
            end else if (rdata_buf == '0) begin
              state_q <= S_DHDR;
            end else begin
              state_q <= S_IBODY;
            end
          end
        end

        S_IBODY: begin
          if (rdata_buf_ready) begin
            instr_addr_q <= instr_addr_q + 32'd4;
            rcv_q        <= rcv_q + 32'd1;
`ifdef LOAD_CHECKSUM_EN
            csum_q       <= csum_q + rdata_buf;
`endif
            if (rcv_q + 32'd1 == ni_q) state_q <= S_DHDR;
          end
        end

        S_DHDR: begin
          if (rdata_buf_ready) begin
            nd_q       <= rdata_buf;
            rcv_q      <= '0;
            resolved_q <= '0;
            if (rdata_buf > MAX_WORDS) begin
              load_err <= 1'b1;
              state_q  <= S_NAK;
            end else if (rdata_buf == '0) begin
`ifdef LOAD_CHECKSUM_EN
              state_q <= S_CSUM;
`else
              state_q <= S_CWAIT;
`endif
            end else begin
              state_q <= S_DBODY;
            end
          end
        end

        S_DBODY: begin
          if (drain || direct) data_req <= 1'b1;
          else if (ack_fire)   data_req <= 1'b0;
          if (ack_fire) data_addr <= data_addr + 32'd4;
          if (to_skid)    skid_vld_q <= 1'b1;
          else if (drain) skid_vld_q <= 1'b0;
          if (drop || extra) overrun <= 1'b1;
          if (take) begin
            rcv_q <= rcv_q + 32'd1;
`ifdef LOAD_CHECKSUM_EN
            csum_q <= csum_q + rdata_buf;
`endif
          end
          resolved_q <= resolved_nxt;
          if (resolved_nxt == nd_q) begin
`ifdef LOAD_CHECKSUM_EN
            state_q <= S_CSUM;
`else
            state_q <= S_CWAIT;
`endif
          end
        end

`ifdef LOAD_CHECKSUM_EN
        S_CSUM: begin
          if (rdata_buf_ready) begin
            if (rdata_buf == csum_q) begin
              // CWAIT passes straight through once the cache is ready
              state_q <= S_CWAIT;
            end else begin
              load_err <= 1'b1;
              state_q  <= S_NAK;
            end
          end
        end
`endif

        S_CWAIT: begin
          if (rdata_buf_ready) overrun <= 1'b1;
          if (cache_init_done) state_q <= S_ACK;
        end

        S_ACK: begin
          if (rdata_buf_ready) overrun <= 1'b1;
          if (!tx_busy) begin
            tx_valid <= 1'b1;
            tx_data  <= ACK_BYTE;
            io_stall <= 1'b0;
            state_q  <= S_RUN;
          end
        end

        S_NAK: begin
          if (rdata_buf_ready) overrun <= 1'b1;
          if (!tx_busy) begin
            tx_valid <= 1'b1;
            tx_data  <= NAK_BYTE;
            state_q  <= S_ERR;
          end
        end

        S_RUN: begin
          io_stall <= 1'b0;
        end

        S_ERR: begin
          io_stall <= 1'b1;
        end

        default: begin
          state_q <= S_ERR;
        end
      endcase
    end
  end

  // --- data payload stage (no reset on payload registers) ---
  always_ff @(posedge clk) begin
    if (drain)       data_wd <= skid_data_q;
    else if (direct) data_wd <= rdata_buf;
    if (to_skid) skid_data_q <= rdata_buf;
  end

endmodule

// File: tb/tb_io_load_sequencer.sv
module tb_io_load_sequencer;

  logic        clk;
  logic        rstn;
  logic [31:0] rdata_buf;
  logic        rdata_buf_ready;
  logic        instr_we;
  logic [31:0] instr_addr;
  logic [31:0] instr_wd;
  logic        cache_init_done;
  logic        data_req;
  logic [31:0] data_addr;
  logic [31:0] data_wd;
  logic        data_ack;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_busy;
  logic [31:0] input_wd;
  logic        input_we;
  logic        io_stall;
  logic        overrun;
  logic        load_err;

  int checks = 0;
  int errors = 0;

  int ack_delay = 3;
  int ack_wait;

  // Event logs filled by the monitor
  logic [31:0] iw_addr [64];
  logic [31:0] iw_data [64];
  logic [31:0] dw_addr [64];
  logic [31:0] dw_data [64];
  int          iw_n = 0;
  int          dw_n = 0;
  int          tx_n = 0;
  int          in_n = 0;
  logic [7:0]  tx_last = 8'h00;
  logic [31:0] in_last = 32'h0;

  int iw_b, dw_b, tx_b, in_b;

  io_load_sequencer dut (
    .clk             (clk),
    .rstn            (rstn),
    .rdata_buf       (rdata_buf),
    .rdata_buf_ready (rdata_buf_ready),
    .instr_we        (instr_we),
    .instr_addr      (instr_addr),
    .instr_wd        (instr_wd),
    .cache_init_done (cache_init_done),
    .data_req        (data_req),
    .data_addr       (data_addr),
    .data_wd         (data_wd),
    .data_ack        (data_ack),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_busy         (tx_busy),
    .input_wd        (input_wd),
    .input_we        (input_we),
    .io_stall        (io_stall),
    .overrun         (overrun),
    .load_err        (load_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Cache model: ack pulse a fixed number of cycles after a request appears
  initial begin
    data_ack = 1'b0;
    ack_wait = 0;
    forever begin
      @(posedge clk); #1;
      if (data_ack) data_ack = 1'b0;
      else if (data_req) begin
        if (ack_wait >= ack_delay) begin
          data_ack = 1'b1;
          ack_wait = 0;
        end else begin
          ack_wait = ack_wait + 1;
        end
      end else begin
        ack_wait = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (instr_we && iw_n < 64) begin
      iw_addr[iw_n] = instr_addr;
      iw_data[iw_n] = instr_wd;
      iw_n = iw_n + 1;
    end
    if (data_req && data_ack && dw_n < 64) begin
      dw_addr[dw_n] = data_addr;
      dw_data[dw_n] = data_wd;
      dw_n = dw_n + 1;
    end
    if (tx_valid) begin
      tx_last = tx_data;
      tx_n = tx_n + 1;
    end
    if (input_we) begin
      in_last = input_wd;
      in_n = in_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    rdata_buf = w;
    rdata_buf_ready = 1'b1;
    @(posedge clk); #1;
    rdata_buf_ready = 1'b0;
  endtask

  task automatic snap();
    iw_b = iw_n;
    dw_b = dw_n;
    tx_b = tx_n;
    in_b = in_n;
  endtask

  task automatic wait_tx(input string tag, input int limit);
    int i;
    i = 0;
    while (tx_n == tx_b && i < limit) begin
      @(posedge clk); #1;
      i++;
    end
    check(tag, 32'(tx_n != tx_b), 32'd1);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    rdata_buf = 32'h0;
    rdata_buf_ready = 1'b0;
    cache_init_done = 1'b1;
    tx_busy = 1'b0;
    ack_delay = 3;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    rstn = 1'b0;
    #2;
    check("rst_io_stall", 32'(io_stall), 32'd1);
    check("rst_data_req", 32'(data_req), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_overrun",  32'(overrun),  32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    check("rst_data_addr", data_addr, 32'h0004_0000);
    check("rst_instr_addr", instr_addr, 32'h0);
    @(posedge clk); #1 rstn = 1'b1;

    // Basic load: 2 instr words, 1 data word
    snap();
    send_word(32'd2);
    send_word(32'h1111_1111);
    send_word(32'h2222_2222);
    send_word(32'd1);
    send_word(32'hD0D0_D0D0);
    idle(12);
`ifdef LOAD_CHECKSUM_EN
    send_word(32'h0404_0403);
`endif
    wait_tx("t1_tx_seen", 200);
    check("t1_tx_byte", 32'(tx_last), 32'hAA);
    check("t1_iw_cnt", 32'(iw_n - iw_b), 32'd2);
    check("t1_iw0_addr", iw_addr[iw_b], 32'h0);
    check("t1_iw0_data", iw_data[iw_b], 32'h1111_1111);
    check("t1_iw1_addr", iw_addr[iw_b + 1], 32'h4);
    check("t1_iw1_data", iw_data[iw_b + 1], 32'h2222_2222);
    check("t1_dw_cnt", 32'(dw_n - dw_b), 32'd1);
    check("t1_dw0_addr", dw_addr[dw_b], 32'h0004_0000);
    check("t1_dw0_data", dw_data[dw_b], 32'hD0D0_D0D0);
    idle(1);
    check("t1_io_stall", 32'(io_stall), 32'd0);
    send_word(32'h1234_5678);
    check("t1_in_cnt", 32'(in_n - in_b), 32'd1);
    check("t1_in_word", in_last, 32'h1234_5678);
    check("t1_overrun", 32'(overrun), 32'd0);
    check("t1_load_err", 32'(load_err), 32'd0);
    check("t1_tx_once", 32'(tx_n - tx_b), 32'd1);

    // Empty load with cache not ready; a stray word during CWAIT
    do_reset();
    cache_init_done = 1'b0;
    snap();
    send_word(32'd0);
    send_word(32'd0);
`ifdef LOAD_CHECKSUM_EN
    send_word(32'd0);
`endif
    idle(2);
    send_word(32'h0000_DEAD);
    idle(10);
    check("t2_no_tx_yet", 32'(tx_n - tx_b), 32'd0);
    check("t2_stall_held", 32'(io_stall), 32'd1);
    check("t2_overrun", 32'(overrun), 32'd1);
    cache_init_done = 1'b1;
    wait_tx("t2_tx_seen", 50);
    check("t2_tx_byte", 32'(tx_last), 32'hAA);
    idle(1);
    check("t2_io_stall", 32'(io_stall), 32'd0);
    check("t2_no_writes", 32'((iw_n - iw_b) + (dw_n - dw_b)), 32'd0);

    // Instruction header over the limit
    do_reset();
    snap();
    send_word(32'h0001_0001);
    wait_tx("t3_tx_seen", 50);
    check("t3_tx_byte", 32'(tx_last), 32'h55);
    check("t3_load_err", 32'(load_err), 32'd1);
    send_word(32'd1);
    send_word(32'd2);
    send_word(32'd3);
    idle(5);
    check("t3_io_stall", 32'(io_stall), 32'd1);
    check("t3_no_writes", 32'((iw_n - iw_b) + (dw_n - dw_b) + (in_n - in_b)), 32'd0);
    check("t3_tx_once", 32'(tx_n - tx_b), 32'd1);

    // Data header over the limit
    do_reset();
    snap();
    send_word(32'd0);
    send_word(32'h0001_0001);
    wait_tx("t4_tx_seen", 50);
    check("t4_tx_byte", 32'(tx_last), 32'h55);
    check("t4_load_err", 32'(load_err), 32'd1);

    // Skid and overrun: three back-to-back data words, slow acks
    do_reset();
    ack_delay = 20;
    snap();
    send_word(32'd0);
    send_word(32'd3);
    send_word(32'hA000_0001);
    send_word(32'hA000_0002);
    send_word(32'hA000_0003);
    check("t5_overrun", 32'(overrun), 32'd1);
    idle(80);
`ifdef LOAD_CHECKSUM_EN
    send_word(32'hE000_0006);
`endif
    wait_tx("t5_tx_seen", 100);
    check("t5_tx_byte", 32'(tx_last), 32'hAA);
    check("t5_dw_cnt", 32'(dw_n - dw_b), 32'd2);
    check("t5_dw0_addr", dw_addr[dw_b], 32'h0004_0000);
    check("t5_dw0_data", dw_data[dw_b], 32'hA000_0001);
    check("t5_dw1_addr", dw_addr[dw_b + 1], 32'h0004_0004);
    check("t5_dw1_data", dw_data[dw_b + 1], 32'hA000_0002);

    // Transmitter busy at ACK
    do_reset();
    tx_busy = 1'b1;
    snap();
    send_word(32'd0);
    send_word(32'd0);
`ifdef LOAD_CHECKSUM_EN
    send_word(32'd0);
`endif
    idle(50);
    check("t6_tx_held", 32'(tx_n - tx_b), 32'd0);
    check("t6_stall_held", 32'(io_stall), 32'd1);
    tx_busy = 1'b0;
    wait_tx("t6_tx_seen", 20);
    idle(5);
    check("t6_tx_once", 32'(tx_n - tx_b), 32'd1);
    check("t6_tx_byte", 32'(tx_last), 32'hAA);

    // Reset while a data write is outstanding drops data_req at once
    do_reset();
    ack_delay = 100;
    send_word(32'd0);
    send_word(32'd1);
    send_word(32'hCAFE_0000);
    idle(2);
    check("t7_req_up", 32'(data_req), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("t7_req_async_drop", 32'(data_req), 32'd0);
    check("t7_addr_base", data_addr, 32'h0004_0000);
    @(posedge clk); #1 rstn = 1'b1;
    ack_delay = 3;

`ifdef LOAD_CHECKSUM_EN
    // Checksum match
    do_reset();
    snap();
    send_word(32'd1);
    send_word(32'd5);
    send_word(32'd1);
    send_word(32'd7);
    idle(10);
    send_word(32'd12);
    wait_tx("t8_tx_seen", 50);
    check("t8_tx_byte", 32'(tx_last), 32'hAA);
    check("t8_load_err", 32'(load_err), 32'd0);

    // Checksum mismatch
    do_reset();
    snap();
    send_word(32'd1);
    send_word(32'd5);
    send_word(32'd1);
    send_word(32'd7);
    idle(10);
    send_word(32'd13);
    wait_tx("t9_tx_seen", 50);
    check("t9_tx_byte", 32'(tx_last), 32'h55);
    check("t9_load_err", 32'(load_err), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
